// File: rtl/fb_pkg.sv
// Shared types for the framebuffer stream reader: pixel/coordinate widths,
// the buffered beat format and the read-side FSM state.
package fb_pkg;
  localparam int PIX_W = 15;
  localparam int X_W   = 10;
  localparam int Y_W   = 10;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic [X_W-1:0]   xcoord_t;
  typedef logic [Y_W-1:0]   ycoord_t;

  typedef struct packed {
    ycoord_t y;
    xcoord_t x;
  } fb_addr_t;

  typedef struct packed {
    pixel_t data;
    logic   sof;
    logic   eol;
  } fb_beat_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} rd_state_t;
endpackage

// File: rtl/pix_fifo.sv
// Synchronous power-of-two FIFO of pixel beats; push while full is only
// accepted together with a pop, pop while empty is ignored.
module pix_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  fb_beat_t               din_i,
  input  logic                   pop_i,
  output fb_beat_t               dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);

  fb_beat_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/fb_stream_reader.sv
// Raster-order framebuffer reader: issues RAM reads under credit control and
// streams the returned pixels out with sof/eol tags.
module fb_stream_reader
  import fb_pkg::*;
#(
  parameter int H_PIXELS   = 640,
  parameter int V_LINES    = 480,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 rd_en,
  output logic [Y_W+X_W-1:0]   rd_addr,
  input  pixel_t               rd_data,
  output pixel_t               m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_sof,
  output logic                 m_eol,
  output logic                 busy,
  output logic                 frame_done,
  output rd_state_t            dbg_state_o
);
  localparam int      CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int      INF_W  = $clog2(RD_LAT + 1) + 1;
  localparam xcoord_t X_LAST = xcoord_t'(H_PIXELS - 1);
  localparam ycoord_t Y_LAST = ycoord_t'(V_LINES - 1);

  rd_state_t         state_q, state_d;
  xcoord_t           x_q, x_d;
  ycoord_t           y_q, y_d;
  logic [INF_W-1:0]  inflight_q, inflight_d;
  logic              frame_done_q, frame_done_d;
  logic [RD_LAT-1:0] vld_pipe_q, sof_pipe_q, eol_pipe_q;

  logic              issue, credit_ok, push, pop;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  fb_beat_t          fifo_din, fifo_head;

  // Stream handshake: a beat transfers on any edge where m_valid && m_ready;
  // once m_valid is raised the beat and its tags hold until that transfer.
  assign pop  = !fifo_empty && m_ready;
  assign push = vld_pipe_q[RD_LAT-1];

  // A pop in the same cycle frees a credit, which keeps the stream bubble-free.
  always_comb begin
    credit_ok = (int'(fifo_count) + int'(inflight_q) - int'(pop)) < FIFO_DEPTH;
  end

  assign issue = (state_q == ISSUE) && credit_ok;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = ISSUE;
      ISSUE: begin
        if (credit_ok) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d     = '0;
              state_d = DRAIN;
            end else begin
              y_d = y_q + ycoord_t'(1);
            end
          end else begin
            x_d = x_q + xcoord_t'(1);
          end
        end
      end
      DRAIN: begin
        // Nothing in flight and one beat left leaving: that is the last pixel.
        if (pop && fifo_count == CNT_W'(1) && inflight_q == '0) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({issue, push})
      2'b10:   inflight_d = inflight_q + INF_W'(1);
      2'b01:   inflight_d = inflight_q - INF_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      inflight_q   <= '0;
      frame_done_q <= 1'b0;
      vld_pipe_q   <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      inflight_q    <= inflight_d;
      frame_done_q  <= frame_done_d;
      vld_pipe_q[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
    end
  end

  // Tags travel beside the read so they meet rd_data at the FIFO input.
  always_ff @(posedge clk) begin
    sof_pipe_q[0] <= (x_q == '0) && (y_q == '0);
    eol_pipe_q[0] <= (x_q == X_LAST);
    for (int i = 1; i < RD_LAT; i++) begin
      sof_pipe_q[i] <= sof_pipe_q[i-1];
      eol_pipe_q[i] <= eol_pipe_q[i-1];
    end
  end

  assign fifo_din = '{data: rd_data, sof: sof_pipe_q[RD_LAT-1], eol: eol_pipe_q[RD_LAT-1]};

  pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rd_en       = issue;
  assign rd_addr     = {y_q, x_q};
  assign m_valid     = !fifo_empty;
  assign m_data      = fifo_empty ? '0 : fifo_head.data;
  assign m_sof       = !fifo_empty && fifo_head.sof;
  assign m_eol       = !fifo_empty && fifo_head.eol;
  assign busy        = (state_q != IDLE);
  assign frame_done  = frame_done_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_fb_stream_reader.sv
// Bench for fb_stream_reader: a 4x2 RD_LAT=1 instance and a 40x12 RD_LAT=3
// instance, each with a RAM model and an expected-beat scoreboard.
module tb_fb_stream_reader;
  import fb_pkg::*;

  localparam int BH = 40;
  localparam int BV = 12;
  localparam int BN = BH * BV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;

  // small instance
  logic s_start, s_rd_en, s_m_valid, s_m_ready, s_m_sof, s_m_eol, s_busy, s_done;
  logic [19:0] s_rd_addr;
  pixel_t s_rd_data, s_m_data;
  rd_state_t s_state;
  // big instance
  logic b_start, b_rd_en, b_m_valid, b_m_ready, b_m_sof, b_m_eol, b_busy, b_done;
  logic [19:0] b_rd_addr;
  pixel_t b_rd_data, b_m_data, b_p1, b_p2;
  rd_state_t b_state;

  fb_stream_reader #(.H_PIXELS(4), .V_LINES(2), .RD_LAT(1), .FIFO_DEPTH(4)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
    .rd_data(s_rd_data), .m_data(s_m_data), .m_valid(s_m_valid), .m_ready(s_m_ready),
    .m_sof(s_m_sof), .m_eol(s_m_eol), .busy(s_busy), .frame_done(s_done),
    .dbg_state_o(s_state)
  );

  fb_stream_reader #(.H_PIXELS(BH), .V_LINES(BV), .RD_LAT(3), .FIFO_DEPTH(8)) u_big (
    .clk(clk), .rst(rst), .start(b_start), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready),
    .m_sof(b_m_sof), .m_eol(b_m_eol), .busy(b_busy), .frame_done(b_done),
    .dbg_state_o(b_state)
  );

  // RAM models: data = low 15 address bits, RD_LAT cycles after the read
  always @(posedge clk) s_rd_data <= s_rd_addr[14:0];
  always @(posedge clk) begin
    b_p1      <= b_rd_addr[14:0];
    b_p2      <= b_p1;
    b_rd_data <= b_p2;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboards: beat = {last, data, sof, eol}
  logic [19:0] s_addr_q[$], b_addr_q[$];
  logic [17:0] s_exp_q[$], b_exp_q[$];
  int s_issued, s_hs, s_sof_n, s_eol_n, s_done_n;
  int b_issued, b_hs, b_sof_n, b_eol_n, b_done_n, b_first, b_last;
  logic s_last_f, s_stall, b_last_f, b_stall;
  logic [16:0] s_hold, b_hold;

  task automatic push_frame_s();
    logic [19:0] a;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++) begin
        a = 20'(y * 1024 + x);
        s_addr_q.push_back(a);
        s_exp_q.push_back({(y == 1 && x == 3), a[14:0], (x == 0 && y == 0), (x == 3)});
      end
  endtask

  task automatic push_frame_b();
    logic [19:0] a;
    for (int y = 0; y < BV; y++)
      for (int x = 0; x < BH; x++) begin
        a = 20'(y * 1024 + x);
        b_addr_q.push_back(a);
        b_exp_q.push_back({(y == BV-1 && x == BH-1), a[14:0], (x == 0 && y == 0), (x == BH-1)});
      end
  endtask

  initial begin : mon_small
    logic [19:0] a;
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        s_addr_q.delete(); s_exp_q.delete();
        s_issued = 0; s_hs = 0; s_sof_n = 0; s_eol_n = 0; s_done_n = 0;
        s_last_f = 1'b0; s_stall = 1'b0;
      end else begin
        if (s_last_f || s_done) begin
          check_eq("s_frame_done", s_done, s_last_f);
          if (s_last_f) check_eq("s_busy_fall", s_busy, 0);
          if (s_done) s_done_n++;
          s_last_f = 1'b0;
        end
        if (s_stall) check_eq("s_hold", {s_m_valid, s_m_data, s_m_sof, s_m_eol}, {1'b1, s_hold});
        if (s_rd_en) begin
          s_issued++;
          if (s_addr_q.size() == 0) check_eq("s_rd_extra", 1, 0);
          else begin a = s_addr_q.pop_front(); check_eq("s_rd_addr", s_rd_addr, a); end
        end
        if (s_m_valid && s_m_ready) begin
          s_hs++;
          if (s_m_sof) s_sof_n++;
          if (s_m_eol) s_eol_n++;
          if (s_exp_q.size() == 0) check_eq("s_beat_extra", 1, 0);
          else begin
            e = s_exp_q.pop_front();
            check_eq("s_beat", {s_m_data, s_m_sof, s_m_eol}, e[16:0]);
            s_last_f = e[17];
          end
        end
        check_eq("s_credit", (s_issued - s_hs) <= 4, 1);
        s_stall = s_m_valid && !s_m_ready;
        s_hold  = {s_m_data, s_m_sof, s_m_eol};
      end
    end
  end

  initial begin : mon_big
    logic [19:0] a;
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        b_addr_q.delete(); b_exp_q.delete();
        b_issued = 0; b_hs = 0; b_sof_n = 0; b_eol_n = 0; b_done_n = 0;
        b_first = 0; b_last = 0; b_last_f = 1'b0; b_stall = 1'b0;
      end else begin
        if (b_last_f || b_done) begin
          check_eq("b_frame_done", b_done, b_last_f);
          if (b_last_f) check_eq("b_busy_fall", b_busy, 0);
          if (b_done) b_done_n++;
          b_last_f = 1'b0;
        end
        if (b_stall) check_eq("b_hold", {b_m_valid, b_m_data, b_m_sof, b_m_eol}, {1'b1, b_hold});
        if (b_rd_en) begin
          b_issued++;
          if (b_addr_q.size() == 0) check_eq("b_rd_extra", 1, 0);
          else begin a = b_addr_q.pop_front(); check_eq("b_rd_addr", b_rd_addr, a); end
        end
        if (b_m_valid && b_m_ready) begin
          b_hs++;
          if (b_m_sof) b_sof_n++;
          if (b_m_eol) b_eol_n++;
          if (b_exp_q.size() == 0) check_eq("b_beat_extra", 1, 0);
          else begin
            e = b_exp_q.pop_front();
            check_eq("b_beat", {b_m_data, b_m_sof, b_m_eol}, e[16:0]);
            if (e[1]) b_first = cyc;
            if (e[17]) b_last = cyc;
            b_last_f = e[17];
          end
        end
        check_eq("b_credit", (b_issued - b_hs) <= 8, 1);
        b_stall = b_m_valid && !b_m_ready;
        b_hold  = {b_m_data, b_m_sof, b_m_eol};
      end
    end
  end

  task automatic pulse_s();
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
  endtask

  task automatic pulse_b();
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
  endtask

  task automatic wait_s_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!s_busy && s_exp_q.size() == 0) break;
    end
    if (i == budget) check_eq("s_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_b_idle(input int budget, input logic rand_ready);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (rand_ready) b_m_ready = 1'($urandom_range(0, 1));
      if (!b_busy && b_exp_q.size() == 0) break;
    end
    if (i == budget) check_eq("b_timeout", 0, 1);
    b_m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_s_hs(input int target, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (s_hs >= target) break;
      @(posedge clk); #1;
    end
    if (i == budget) check_eq("s_hs_timeout", 0, 1);
  endtask

  initial begin : main
    int hs0, done0, i;
    s_start = 1'b0; s_m_ready = 1'b1;
    b_start = 1'b0; b_m_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_s_outs", {s_rd_en, s_rd_addr, s_m_valid, s_m_sof, s_m_eol, s_busy, s_done}, 0);
    check_eq("rst_s_data", s_m_data, 0);
    check_eq("rst_b_outs", {b_rd_en, b_rd_addr, b_m_valid, b_m_sof, b_m_eol, b_busy, b_done}, 0);
    rst = 1'b0;

    // 1: basic frame, latency
    push_frame_s();
    @(posedge clk); #1 s_start = 1'b1;
    check_eq("t1_busy_pre", s_busy, 0);
    @(posedge clk); #1 s_start = 1'b0;
    check_eq("t1_c1_rd", {s_rd_en, s_rd_addr}, {1'b1, 20'h0});
    check_eq("t1_c1_busy", s_busy, 1);
    check_eq("t1_c1_valid", s_m_valid, 0);
    @(posedge clk); #1 check_eq("t1_c2_valid", s_m_valid, 0);
    @(posedge clk); #1 check_eq("t1_c3_valid", {s_m_valid, s_m_sof}, 2'b11);
    wait_s_idle(100);
    check_eq("t1_hs", s_hs, 8);
    check_eq("t1_sof", s_sof_n, 1);
    check_eq("t1_eol", s_eol_n, 2);
    check_eq("t1_done", s_done_n, 1);
    check_eq("t1_busy", s_busy, 0);

    // 2: backpressure from pixel 2 for 10 cycles
    hs0 = s_hs; done0 = s_done_n;
    push_frame_s();
    pulse_s();
    wait_s_hs(hs0 + 1, 50);
    s_m_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("t2_stall_rd_en", s_rd_en, 0);
    check_eq("t2_stall_valid", s_m_valid, 1);
    s_m_ready = 1'b1;
    wait_s_idle(100);
    check_eq("t2_hs", s_hs - hs0, 8);
    check_eq("t2_done", s_done_n - done0, 1);

    // 3: start ignored in ISSUE and DRAIN
    hs0 = s_hs; done0 = s_done_n;
    push_frame_s();
    pulse_s();
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    for (i = 0; i < 30 && s_state != DRAIN; i++) begin
      @(posedge clk); #1;
    end
    check_eq("t3_reach_drain", s_state, DRAIN);
    s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    wait_s_idle(100);
    repeat (5) @(posedge clk);
    #1;
    check_eq("t3_hs", s_hs - hs0, 8);
    check_eq("t3_done", s_done_n - done0, 1);
    check_eq("t3_idle", {s_busy, s_rd_en, s_m_valid}, 0);
    push_frame_s();
    pulse_s();
    wait_s_idle(100);
    check_eq("t3_hs2", s_hs - hs0, 16);
    check_eq("t3_done2", s_done_n - done0, 2);

    // 4: reset at pixel 5
    hs0 = s_hs;
    push_frame_s();
    pulse_s();
    wait_s_hs(hs0 + 4, 50);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_eq("t4_rst_outs", {s_rd_en, s_rd_addr, s_m_valid, s_m_sof, s_m_eol, s_busy, s_done}, 0);
    check_eq("t4_rst_data", s_m_data, 0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check_eq("t4_no_done", {s_done, s_m_valid}, 0);
    end
    push_frame_s();
    pulse_s();
    check_eq("t4_first_rd", {s_rd_en, s_rd_addr}, {1'b1, 20'h0});
    wait_s_idle(100);
    check_eq("t4_hs", s_hs, 8);
    check_eq("t4_sof", s_sof_n, 1);
    check_eq("t4_done", s_done_n, 1);

    // 5: big frame, random m_ready
    push_frame_b();
    pulse_b();
    wait_b_idle(20000, 1'b1);
    check_eq("t5_hs", b_hs, BN);
    check_eq("t5_eol", b_eol_n, BV);
    check_eq("t5_sof", b_sof_n, 1);
    check_eq("t5_done", b_done_n, 1);

    // 6: big frame, m_ready held high
    hs0 = b_hs; done0 = b_done_n;
    push_frame_b();
    pulse_b();
    wait_b_idle(5000, 1'b0);
    check_eq("t6_hs", b_hs - hs0, BN);
    check_eq("t6_done", b_done_n - done0, 1);
    check_eq("t6_cycles", b_last - b_first + 1, BN);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_stream_reader.md
Name: fb_stream_reader

Overview:
- Reads a finished frame out of the 15-bit RGB framebuffer RAM and emits it as a valid/ready pixel stream with start-of-frame and end-of-line markers.
- Scans addresses {y,x} in raster order. Absorbs the RAM read latency and downstream backpressure with a small credit-controlled FIFO.
- Sits on the RAM read port, replacing the free-running read address counter, and feeds the display/compute pipeline.

Parameters:
- PIX_W, 15, pixel width (RGB555)
- X_W, 10, column index width
- Y_W, 10, row index width
- H_PIXELS, 640, pixels per line (2..2^X_W)
- V_LINES, 480, lines per frame (1..2^Y_W)
- RD_LAT, 1, RAM read latency in cycles (1..3)
- FIFO_DEPTH, 4, output buffer entries; must be >= RD_LAT+2 and a power of two

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a frame when idle
- rd_en  out  1  RAM read strobe
- rd_addr  out  Y_W+X_W  RAM read address {y,x}
- rd_data  in  PIX_W  RAM read data, valid RD_LAT cycles after rd_en
- m_data  out  PIX_W  pixel
- m_valid  out  1  pixel valid
- m_ready  in  1  downstream accepts
- m_sof  out  1  qualifies m_data as pixel (0,0)
- m_eol  out  1  qualifies m_data as last pixel of a line (x = H_PIXELS-1)
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last pixel handshake

Behaviour:
- Reset (synchronous, rst=1 at an edge): all outputs are 0 at that edge, including rd_en, rd_addr, m_valid, m_sof, m_eol, busy and frame_done. The FSM goes to IDLE, the FIFO is emptied, in-flight reads are discarded, and x/y return to 0. Reset mid-frame aborts the frame with no frame_done.
- FSM IDLE:
  - start=1 -> ISSUE, busy=1 from the next cycle.
  - start is ignored in ISSUE and DRAIN.
- FSM ISSUE:
  - rd_en is asserted when credits allow: fifo_count + inflight < FIFO_DEPTH, where a same-cycle pop frees a credit.
  - Each issue advances x. When x wraps from H_PIXELS-1 to 0, y increments.
  - Issuing pixel (H_PIXELS-1, V_LINES-1) -> DRAIN.
- FSM DRAIN:
  - No reads are issued.
  - When the FIFO is empty, inflight=0 and the last pixel has handshaken -> IDLE.
  - frame_done=1 for exactly one cycle, the cycle after that handshake. busy falls in the same cycle.
- Tags: sof/eol are computed at issue and delayed RD_LAT cycles alongside the read. The FIFO captures {rd_data, sof, eol} in the cycle rd_data is valid.
- Output:
  - m_valid = FIFO not empty. m_data/m_sof/m_eol show the FIFO head.
  - A handshake is m_valid & m_ready, which pops the head.
  - While m_valid=1 and m_ready=0, m_data/m_sof/m_eol hold stable.
- Latency (start sampled at edge 0):
  - rd_en high in cycle 1, addr 0.
  - rd_data valid in cycle 1+RD_LAT.
  - m_valid high from cycle 2+RD_LAT (cycle 3 for RD_LAT=1).
- Throughput: with m_ready held high, one pixel per cycle sustained, with no bubbles across line wrap.
- Ordering: strict raster order; no pixel is dropped or duplicated under any m_ready pattern.
- FIFO is never overrun: credit accounting guarantees this. Simultaneous push and pop at full or empty is legal.
- Widths: inflight counter is clog2(RD_LAT+1)+1 bits; fifo_count is clog2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared package fb_pkg holds:
  - constants PIX_W, X_W, Y_W
  - typedefs pixel_t (PIX_W bits), xcoord_t, ycoord_t, fb_addr_t ({ycoord_t, xcoord_t})
  - enum rd_state_t {IDLE, ISSUE, DRAIN}
- One sub-module, pix_fifo: synchronous FIFO of {pixel_t, sof, eol}, parameter DEPTH, outputs count/full/empty.

Test Plan:
1. H_PIXELS=4, V_LINES=2, RAM model returns rd_data = low 15 bits of the address, m_ready=1, start at cycle 0 -> rd_addr sequence 0x000,0x001,0x002,0x003,0x400..0x403. First m_valid at cycle 3. m_sof only on the first pixel, m_eol on pixels 4 and 8. frame_done at one cycle after the 8th handshake; busy low from then.
2. Same frame, m_ready=0 from pixel 2 for 10 cycles -> rd_en stops after at most 4 buffered+in-flight reads. m_data holds stable while stalled. After release, all 8 pixels arrive in order with none lost or duplicated.
3. start pulsed again in ISSUE and in DRAIN -> ignored. Exactly one frame is emitted; a later start in IDLE emits a second identical frame.
4. rst asserted at pixel 5 of a 4x2 frame -> next cycle all outputs are 0 and no frame_done. A new start scans from rd_addr 0x000 with m_sof on the first pixel.
5. 640x480 run, RD_LAT=3, FIFO_DEPTH=8, 50% random m_ready -> scoreboard matches all 307200 pixels. eol count is 480, sof count is 1, and frame_done pulses once.
6. Same 640x480 run, RD_LAT=3, FIFO_DEPTH=8, m_ready=1 throughout -> 307200 handshakes in 307200 consecutive cycles, including across line wraps.
